mem_sram_ctrl: RTL and testbench

MEM_SRAM_CTRL -- requirements
Module: mem_sram_ctrl

---
 rtl/mem_sram_ctrl_if.sv | 30 +++
 rtl/mem_sram_ctrl.sv | 150 +++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_ctrl_if.sv
// SRAM bus between the memory-stage controller and a 16-bit asynchronous SRAM.
//   sram_addr   : halfword address
//   sram_dq_out : write data, valid while sram_dq_oe is high
//   sram_dq_in  : read data returned by the SRAM
//   sram_dq_oe  : write-data drive enable
//   sram_we_n   : active-low write strobe
// master : controller side, slave : SRAM side.
interface mem_sram_ctrl_if;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;

  modport master (
    output sram_addr,
    output sram_dq_out,
    output sram_dq_oe,
    output sram_we_n,
    input  sram_dq_in
  );

  modport slave (
    input  sram_addr,
    input  sram_dq_out,
    input  sram_dq_oe,
    input  sram_we_n,
    output sram_dq_in
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: turns a 32-bit load/store from the EXE stage into two 16-bit SRAM
// half-accesses (low half first), stalling the pipeline via freeze until the access finishes.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   wb_en_in, mem_*_en_in, alu_result_in, val_rm_in, dest_in : EXE stage register outputs
//   wb_en_out, mem_read_en_out, alu_result_out, dest_out     : combinational pass-throughs
//   mem_read_value      : registered load result
//   freeze              : pipeline stall while an access is incomplete
//   sram                : SRAM bus (master side)
module mem_sram_ctrl #(
  parameter int unsigned SRAM_WAIT = 2,           // cycles per half-access, 2..7
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en_in,
  input  logic          mem_read_en_in,
  input  logic          mem_write_en_in,
  input  logic [31:0]   alu_result_in,
  input  logic [31:0]   val_rm_in,
  input  logic [3:0]    dest_in,
  output logic          wb_en_out,
  output logic          mem_read_en_out,
  output logic [31:0]   alu_result_out,
  output logic [3:0]    dest_out,
  output logic [31:0]   mem_read_value,
  output logic          freeze,
  mem_sram_ctrl_if.master sram
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StDone} state_e;

  localparam logic [2:0] CntLast = 3'(SRAM_WAIT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] mem_read_value_q, mem_read_value_d;
  logic        half_end;
  logic [16:0] word_idx;

  assign half_end = (cnt_q == CntLast);

  // Bits [18:2] of (alu_result_in - BASE_ADDR); the borrow out of bits [1:0] is folded in so
  // only the slice that reaches the SRAM address is computed.
  assign word_idx = alu_result_in[18:2] - BASE_ADDR[18:2]
                  - 17'(alu_result_in[1:0] < BASE_ADDR[1:0]);

  assign wb_en_out       = wb_en_in;
  assign mem_read_en_out = mem_read_en_in;
  assign alu_result_out  = alu_result_in;
  assign dest_out        = dest_in;
  assign mem_read_value  = mem_read_value_q;
  assign freeze          = (mem_read_en_in | mem_write_en_in) & (state_q != StDone);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    mem_read_value_d = mem_read_value_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (mem_write_en_in) begin
          state_d = StWrLo;
        end else if (mem_read_en_in) begin
          state_d = StRdLo;
        end
      end
      StRdLo: begin
        if (half_end) begin
          state_d                = StRdHi;
          cnt_d                  = 3'd0;
          mem_read_value_d[15:0] = sram.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRdHi: begin
        if (half_end) begin
          state_d                 = StDone;
          cnt_d                   = 3'd0;
          mem_read_value_d[31:16] = sram.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrLo: begin
        if (half_end) begin
          state_d = StWrHi;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StWrHi: begin
        if (half_end) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // SRAM bus decode; everything idles at addr 0, strobe high, bus released.
  always_comb begin
    sram.sram_addr   = 18'd0;
    sram.sram_dq_out = 16'd0;
    sram.sram_dq_oe  = 1'b0;
    sram.sram_we_n   = 1'b1;
    unique case (state_q)
      StRdLo: sram.sram_addr = {word_idx, 1'b0};
      StRdHi: sram.sram_addr = {word_idx, 1'b1};
      StWrLo: begin
        sram.sram_addr   = {word_idx, 1'b0};
        sram.sram_dq_out = val_rm_in[15:0];
        sram.sram_dq_oe  = 1'b1;
        sram.sram_we_n   = half_end;  // strobe rises on the last cycle to latch the data
      end
      StWrHi: begin
        sram.sram_addr   = {word_idx, 1'b1};
        sram.sram_dq_out = val_rm_in[31:16];
        sram.sram_dq_oe  = 1'b1;
        sram.sram_we_n   = half_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      cnt_q            <= 3'd0;
      mem_read_value_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      mem_read_value_q <= mem_read_value_d;
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
module tb_mem_sram_ctrl;
  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        wb_en_in, mem_read_en_in, mem_write_en_in;
  logic [31:0] alu_result_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        wb_en_out, mem_read_en_out;
  logic [31:0] alu_result_out;
  logic [3:0]  dest_out;
  logic [31:0] mem_read_value;
  logic        freeze;

  mem_sram_ctrl_if sram_bus ();

  mem_sram_ctrl #(
    .SRAM_WAIT(W),
    .BASE_ADDR(32'd1024)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_en_in        (wb_en_in),
    .mem_read_en_in  (mem_read_en_in),
    .mem_write_en_in (mem_write_en_in),
    .alu_result_in   (alu_result_in),
    .val_rm_in       (val_rm_in),
    .dest_in         (dest_in),
    .wb_en_out       (wb_en_out),
    .mem_read_en_out (mem_read_en_out),
    .alu_result_out  (alu_result_out),
    .dest_out        (dest_out),
    .mem_read_value  (mem_read_value),
    .freeze          (freeze),
    .sram            (sram_bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] sram_mem [256];  // SRAM contents, written only by DUT write strobes
  logic [15:0] ref_mem  [256];  // expected contents, written when stimulus is issued
  logic [33:0] wr_q [$];        // expected {addr, data} per write half
  logic [31:0] rd_q [$];        // expected mem_read_value after each access
  logic [31:0] last_read = 32'd0;
  int          wlow = 0;

  assign sram_bus.sram_dq_in = sram_mem[sram_bus.sram_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: each write half must hold we_n low W-1 cycles, then raise it on the last.
  initial begin
    forever begin
      @(negedge clk);
      if (sram_bus.sram_dq_oe) begin
        if (!sram_bus.sram_we_n) begin
          wlow++;
        end else begin
          check("we_low_cycles", 32'(wlow), 32'(W - 1));
          wlow = 0;
          if (wr_q.size() == 0) begin
            check("unexpected_write", 32'd1, 32'd0);
          end else begin
            logic [33:0] w;
            w = wr_q.pop_front();
            check("wr_addr", 32'(sram_bus.sram_addr), 32'(w[33:16]));
            check("wr_data", 32'(sram_bus.sram_dq_out), 32'(w[15:0]));
          end
          sram_mem[sram_bus.sram_addr[7:0]] = sram_bus.sram_dq_out;
        end
      end else begin
        check("we_n_idle", 32'(sram_bus.sram_we_n), 32'd1);
      end
    end
  end

  // Issue one access at posedge+1 and return at posedge+1 of the cycle after DONE, with the
  // request still applied so a following call runs back-to-back.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data);
    logic [31:0] off;
    logic [17:0] sa;
    logic [7:0]  hw;
    logic [31:0] exp;
    int          cycles;
    bit          done;
    mem_read_en_in  = rd;
    mem_write_en_in = wr;
    wb_en_in        = rd;
    alu_result_in   = addr;
    val_rm_in       = data;
    dest_in         = 4'd5;
    off = addr - 32'd1024;
    sa  = {off[18:2], 1'b0};
    hw  = {off[8:2], 1'b0};
    exp = last_read;
    if (wr) begin
      wr_q.push_back({sa, data[15:0]});
      wr_q.push_back({sa | 18'd1, data[31:16]});
      ref_mem[hw]        = data[15:0];
      ref_mem[hw + 8'd1] = data[31:16];
    end else if (rd) begin
      exp       = {ref_mem[hw + 8'd1], ref_mem[hw]};
      last_read = exp;
    end
    rd_q.push_back(exp);
    cycles = 0;
    done   = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (freeze) cycles++;
      else done = 1'b1;
    end
    check("freeze_timeout", 32'(done), 32'd1);
    check("freeze_cycles", 32'(cycles), 32'(2 * W + 1));
    @(posedge clk);
    #1;
    check("read_value", mem_read_value, rd_q.pop_front());
    check("wr_pending", 32'(wr_q.size()), 32'd0);
  endtask

  task automatic idle_op();
    mem_read_en_in  = 1'b0;
    mem_write_en_in = 1'b0;
    wb_en_in        = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] = 16'(i * 16'h0101) ^ 16'hA5C3;
      ref_mem[i]  = 16'(i * 16'h0101) ^ 16'hA5C3;
    end
    rst             = 1'b0;
    wb_en_in        = 1'b0;
    mem_read_en_in  = 1'b0;
    mem_write_en_in = 1'b0;
    alu_result_in   = 32'd0;
    val_rm_in       = 32'd0;
    dest_in         = 4'd0;

    // Reset with no request
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
    check("rst_read_value", mem_read_value, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Non-memory op: zero-latency pass-through, no stall
    wb_en_in      = 1'b1;
    alu_result_in = 32'd7;
    dest_in       = 4'd3;
    #1;
    check("pt_wb_en", 32'(wb_en_out), 32'd1);
    check("pt_alu", alu_result_out, 32'd7);
    check("pt_dest", 32'(dest_out), 32'd3);
    check("pt_rd_en", 32'(mem_read_en_out), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("nonmem_freeze", 32'(freeze), 32'd0);
      check("nonmem_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
    end
    @(posedge clk);
    #1;
    idle_op();

    // Store then load at 1028 (halfwords 2 and 3)
    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    idle_op();
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    check("pt_rd_en_load", 32'(mem_read_en_out), 32'd1);
    idle_op();
    @(negedge clk);
    check("read_hold", mem_read_value, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Back-to-back random mix; low address bits must be ignored
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      int          op;
      a  = 32'd1024 + 32'($urandom_range(0, 127)) * 32'd4 + 32'($urandom_range(0, 3));
      op = $urandom_range(0, 1);
      access(op == 0, op == 1, a, $urandom);
    end
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    idle_op();
    @(posedge clk);
    #1;

    // Read and write together: the write wins, load result untouched
    access(1'b1, 1'b1, 32'd1100, 32'h1234_5678);
    idle_op();
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'd1100, 32'd0);
    idle_op();
    @(posedge clk);
    #1;

    // Reset asserted in RD_HI; held request restarts from scratch afterwards
    mem_read_en_in = 1'b1;
    alu_result_in  = 32'd1028;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_read_value", mem_read_value, 32'd0);
    check("midrst_we_n", 32'(sram_bus.sram_we_n), 32'd1);
    check("midrst_oe", 32'(sram_bus.sram_dq_oe), 32'd0);
    check("midrst_addr", 32'(sram_bus.sram_addr), 32'd0);
    last_read = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    access(1'b1, 1'b0, 32'd1028, 32'd0);
    idle_op();
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
